// File: rtl/mem_responder.sv
// mem_responder: memory-side responder serving read/write strobes from an internal word array.
// Latency: ack pulses exactly WAIT_CYCLES+1 edges after acceptance; busy spans WAIT_CYCLES+2 cycles.
// Backpressure: none queued; requests presented while busy are dropped and must be re-presented in IDLE.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_rd, req_wr      read / write strobes, sampled only in IDLE (both high = write)
//   req_addr, req_wdata word address and write data, latched at acceptance
//   busy                access in progress
//   ack                 one-cycle completion pulse
//   rdata               read data, valid with ack, held until the next read ack
//   err                 out-of-range flag, valid with ack
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN
//   defined   : addresses >= DEPTH drop writes, return rdata=0 on reads, and raise err with ack
//   undefined : the index is the low address bits (out-of-range addresses wrap), err stays 0
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              busy_d, ack_d, err_d;
  logic [DATA_W-1:0] rdata_d;

  logic              mem_we;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [DATA_W-1:0] mem [DEPTH];

  assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign in_range = (32'(addr_q) < 32'(DEPTH));
`else
  // Every address maps onto the array by its low bits, so nothing is ever out of range.
  assign in_range = 1'b1;
  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic addr_hi_unused;
      assign addr_hi_unused = ^addr_q[ADDR_W-1:IDX_W];
    end
  endgenerate
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    busy_d  = busy;
    ack_d   = ack;
    rdata_d = rdata;
    err_d   = err;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_rd || req_wr) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wr_d    = req_wr;          // read+write together resolves to a write
          cnt_d   = 4'(WAIT_CYCLES);
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // The access itself happens on the edge that enters ACK.
          state_d = ST_ACK;
          ack_d   = 1'b1;
          err_d   = ~in_range;
          if (wr_q) begin
            mem_we = in_range;
          end else begin
            rdata_d = in_range ? mem[idx] : '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      busy    <= busy_d;
      ack     <= ack_d;
      rdata   <= rdata_d;
      err     <= err_d;
    end
  end

  // Array contents survive reset; an aborted access never reaches this write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
